// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: retires LSU results into the register file and turns a flagged
// exception into a single flush + trap redirect followed by a fixed drain window.

package wb_commit_pkg;
  localparam int unsigned XLEN   = 64;
  localparam int unsigned CauseW = 6;

  typedef logic [XLEN-1:0] reg_data_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_wb;
  } decode_t;

  typedef struct packed {
    logic              valid;
    logic [CauseW-1:0] code;
  } except_t;

  typedef struct packed {
    logic      valid;
    reg_data_t pc;
    decode_t   decode;
    except_t   except;
  } issued_instr_t;
endpackage

module wb_commit_unit
  import wb_commit_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 64
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  issued_instr_t i_instr,
  input  reg_data_t     i_data,
  input  reg_data_t     i_mtvec,
  output logic          o_rf_wr_en,
  output logic [4:0]    o_rf_wr_idx,
  output reg_data_t     o_rf_wr_data,
  output logic          o_flush,
  output logic          o_redirect_valid,
  output reg_data_t     o_redirect_pc,
  output reg_data_t     o_epc,
  output reg_data_t     o_cause,
  output logic [CNT_W-1:0] o_retired,
  output logic [CNT_W-1:0] o_cycles,
  output logic          o_busy
);

  localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {StRun, StTrap, StDrain} state_e;

  state_e            state_q, state_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic              wr_en_q, wr_en_d;
  logic [4:0]        wr_idx_q, wr_idx_d;
  reg_data_t         wr_data_q, wr_data_d;
  logic              flush_q, flush_d;
  reg_data_t         redirect_pc_q, redirect_pc_d;
  reg_data_t         epc_q, epc_d;
  reg_data_t         cause_q, cause_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    wr_en_d       = 1'b0;
    wr_idx_d      = wr_idx_q;
    wr_data_d     = wr_data_q;
    flush_d       = 1'b0;
    redirect_pc_d = redirect_pc_q;
    epc_d         = epc_q;
    cause_d       = cause_q;
    retired_d     = retired_q;
    cycles_d      = cycles_q + CNT_W'(1);

    unique case (state_q)
      StRun: begin
        if (i_instr.valid) begin
          // Exception wins over reg_wb: a trapping instruction never writes or retires.
          if (i_instr.except.valid) begin
            epc_d         = i_instr.pc;
            cause_d       = {{(XLEN - CauseW){1'b0}}, i_instr.except.code};
            redirect_pc_d = i_mtvec;
            flush_d       = 1'b1;
            state_d       = StTrap;
          end else begin
            retired_d = retired_q + CNT_W'(1);
            wr_en_d   = i_instr.decode.reg_wb & (i_instr.decode.rd != 5'd0);
            wr_idx_d  = i_instr.decode.rd;
            wr_data_d = i_data;
          end
        end
      end
      StTrap: begin
        state_d = StDrain;
        drain_d = DrainW'(DRAIN_CYCLES - 1);
      end
      StDrain: begin
        if (drain_q == '0) begin
          state_d = StRun;
        end else begin
          drain_d = drain_q - DrainW'(1);
        end
      end
      default: state_d = StRun;
    endcase

    busy_d = (state_d != StRun);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= StRun;
      drain_q       <= '0;
      wr_en_q       <= 1'b0;
      wr_idx_q      <= '0;
      wr_data_q     <= '0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      epc_q         <= '0;
      cause_q       <= '0;
      retired_q     <= '0;
      cycles_q      <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      wr_en_q       <= wr_en_d;
      wr_idx_q      <= wr_idx_d;
      wr_data_q     <= wr_data_d;
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
      epc_q         <= epc_d;
      cause_q       <= cause_d;
      retired_q     <= retired_d;
      cycles_q      <= cycles_d;
      busy_q        <= busy_d;
    end
  end

  assign o_rf_wr_en       = wr_en_q;
  assign o_rf_wr_idx      = wr_idx_q;
  assign o_rf_wr_data     = wr_data_q;
  assign o_flush          = flush_q;
  assign o_redirect_valid = flush_q;
  assign o_redirect_pc    = redirect_pc_q;
  assign o_epc            = epc_q;
  assign o_cause          = cause_q;
  assign o_retired        = retired_q;
  assign o_cycles         = cycles_q;
  assign o_busy           = busy_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Bench for wb_commit_unit: directed scenarios plus random traffic against a reference model
// that tracks commits, traps and the number of cycles the unit still ignores its input.

module tb_wb_commit_unit;
  import wb_commit_pkg::*;

  localparam int unsigned DRAIN_CYCLES = 3;
  localparam int unsigned CNT_W        = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  issued_instr_t    instr;
  reg_data_t        data, mtvec;
  logic             rf_wr_en, flush, redirect_valid, busy;
  logic [4:0]       rf_wr_idx;
  reg_data_t        rf_wr_data, redirect_pc, epc, cause;
  logic [CNT_W-1:0] retired, cycles;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic             m_wr_en, m_flush;
  logic [4:0]       m_idx;
  reg_data_t        m_data, m_rpc, m_epc, m_cause;
  logic [CNT_W-1:0] m_ret, m_cyc;
  int               m_ignore;

  wb_commit_unit #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_instr          (instr),
    .i_data           (data),
    .i_mtvec          (mtvec),
    .o_rf_wr_en       (rf_wr_en),
    .o_rf_wr_idx      (rf_wr_idx),
    .o_rf_wr_data     (rf_wr_data),
    .o_flush          (flush),
    .o_redirect_valid (redirect_valid),
    .o_redirect_pc    (redirect_pc),
    .o_epc            (epc),
    .o_cause          (cause),
    .o_retired        (retired),
    .o_cycles         (cycles),
    .o_busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wr_en = 0; m_flush = 0; m_idx = 0; m_data = 0; m_rpc = 0; m_epc = 0; m_cause = 0;
    m_ret = 0; m_cyc = 0; m_ignore = 0;
  endtask

  // One trap blocks the input for the flush cycle plus the drain window.
  task automatic model_edge();
    m_cyc++;
    m_wr_en = 0;
    m_flush = 0;
    if (m_ignore > 0) begin
      m_ignore--;
    end else if (instr.valid) begin
      if (instr.except.valid) begin
        m_epc    = instr.pc;
        m_cause  = reg_data_t'(instr.except.code);
        m_rpc    = mtvec;
        m_flush  = 1;
        m_ignore = 1 + DRAIN_CYCLES;
      end else begin
        m_ret++;
        m_wr_en = instr.decode.reg_wb && (instr.decode.rd != 0);
        if (m_wr_en) begin
          m_idx  = instr.decode.rd;
          m_data = data;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("wr_en", 64'(rf_wr_en), 64'(m_wr_en));
    if (m_wr_en) begin
      check("wr_idx", 64'(rf_wr_idx), 64'(m_idx));
      check("wr_data", rf_wr_data, m_data);
    end
    check("flush", 64'(flush), 64'(m_flush));
    check("redirect_valid", 64'(redirect_valid), 64'(m_flush));
    check("redirect_pc", redirect_pc, m_rpc);
    check("epc", epc, m_epc);
    check("cause", cause, m_cause);
    check("retired", retired, m_ret);
    check("cycles", cycles, m_cyc);
    check("busy", 64'(busy), 64'(m_ignore != 0));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic v, input logic ex, input reg_data_t pc, input logic [4:0] rd,
                       input logic wb, input logic [5:0] code, input reg_data_t d,
                       input reg_data_t mt);
    instr.valid         = v;
    instr.except.valid  = ex;
    instr.pc            = pc;
    instr.decode.rd     = rd;
    instr.decode.reg_wb = wb;
    instr.except.code   = code;
    data                = d;
    mtvec               = mt;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, 64'(rf_wr_en), 64'd0);
    check({tag, "_flush"}, 64'(flush), 64'd0);
    check({tag, "_epc"}, epc, 64'd0);
    check({tag, "_cause"}, cause, 64'd0);
    check({tag, "_rpc"}, redirect_pc, 64'd0);
    check({tag, "_retired"}, retired, 64'd0);
    check({tag, "_cycles"}, cycles, 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n_busy;
    model_reset();
    drive(0, 0, '0, '0, 0, '0, '0, '0);
    #1;
    check_all_zero("reset");
    step();
    step();
    rst = 1'b0;

    // Five plain commits, one write per cycle
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 64'h1000 + 64'(4 * i), 5'(i + 1), 1, '0, 64'h10 + 64'(i), '0);
      step();
      check("seq_wr_en", 64'(rf_wr_en), 64'd1);
      check("seq_wr_idx", 64'(rf_wr_idx), 64'(i + 1));
    end
    check("retired_after_5", retired, 64'd5);

    // Write to x0 is dropped but still retires
    drive(1, 0, 64'h1014, 5'd0, 1, '0, 64'hDEAD, '0);
    step();
    check("x0_wr_en", 64'(rf_wr_en), 64'd0);
    check("x0_retired", retired, 64'd6);

    // Trap, then valid traffic during TRAP/DRAIN is ignored
    drive(1, 1, 64'h8000_0100, 5'd9, 1, 6'd2, 64'h55, 64'h8000_0000);
    step();
    check("trap_flush", 64'(flush), 64'd1);
    check("trap_rpc", redirect_pc, 64'h8000_0000);
    check("trap_epc", epc, 64'h8000_0100);
    check("trap_cause", cause, 64'd2);
    check("trap_retired", retired, 64'd6);
    n_busy = 1;
    drive(1, 0, 64'h2000, 5'd7, 1, '0, 64'h77, '0);
    for (int i = 0; i < 10 && busy; i++) begin
      step();
      if (busy) n_busy++;
    end
    check("busy_len", 64'(n_busy), 64'd4);
    check("drain_retired", retired, 64'd6);
    step();
    check("post_drain_wr_en", 64'(rf_wr_en), 64'd1);
    check("post_drain_retired", retired, 64'd7);

    // Asynchronous reset in the middle of DRAIN
    drive(1, 1, 64'h3000, 5'd1, 0, 6'd5, '0, 64'h4000);
    step();
    drive(1, 0, 64'h3004, 5'd2, 1, '0, 64'h99, '0);
    step();
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    step();
    step();
    #1;
    rst = 1'b0;
    drive(1, 0, 64'h5000, 5'd3, 1, '0, 64'hABC, '0);
    step();
    check("fresh_retired", retired, 64'd1);
    check("fresh_wr_data", rf_wr_data, 64'hABC);

    // Retire counter wraps
    drive(1, 0, 64'h5004, 5'd4, 1, '0, 64'h1, '0);
    force dut.retired_q = {CNT_W{1'b1}};
    #1;
    release dut.retired_q;
    m_ret = {CNT_W{1'b1}};
    step();
    check("wrap_retired", retired, 64'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) == 0), {$urandom, $urandom},
            5'($urandom), 1'($urandom), 6'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
